card_draw_arbiter: RTL and testbench

//  Shares the single card_generation source among the three hands (dealer, player, split).

---
 rtl/bj_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/card_draw_arbiter.sv | 156 +++++++++++++++
 tb/tb_card_draw_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/bj_pkg.sv
// Shared types and defaults for the blackjack card-draw path.
package bj_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DELIVER = 2'd2,
    ST_SHUFFLE = 2'd3
  } state_t;

  localparam int N_REQ_DEF        = 3;
  localparam int CARD_W_DEF       = 4;
  localparam int TIMEOUT_DEF      = 15;
  localparam int RESHUFFLE_AT_DEF = 40;
  localparam int CNT_W            = 6;

  // Requester indices
  localparam int DEALER = 0;
  localparam int PLAYER = 1;
  localparam int SPLIT  = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at/after ptr, wrapping.
module rr_arbiter #(
  parameter int N_REQ = 3,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [PTR_W-1:0] gnt_idx
);

  int   idx;
  logic found;

  // Scan requesters starting at ptr; first hit wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(ptr) + i) % N_REQ;
      if (!found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/card_draw_arbiter.sv
// Shares one card source among dealer/player/split hands. One draw in flight,
// round-robin grant, invalid-card retry, WAIT timeout, reshuffle after a deck.
module card_draw_arbiter
  import bj_pkg::*;
#(
  parameter int N_REQ        = N_REQ_DEF,
  parameter int CARD_W       = CARD_W_DEF,
  parameter int TIMEOUT      = TIMEOUT_DEF,
  parameter int RESHUFFLE_AT = RESHUFFLE_AT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [N_REQ-1:0]  req,
  output logic [N_REQ-1:0]  gnt,
  output logic [CARD_W-1:0] card_out,
  output logic [N_REQ-1:0]  card_valid,
  output logic              src_req,
  input  logic              src_ack,
  input  logic [CARD_W-1:0] src_card,
  output logic              busy,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  cards_dealt,
  output logic              reshuffle_req,
  input  logic              reshuffle_done
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  state_t              state, state_nxt;
  logic [PTR_W-1:0]    ptr, ptr_nxt, win, win_nxt;
  logic [TMR_W-1:0]    timer, timer_nxt;
  logic [CARD_W-1:0]   card_q, card_q_nxt, card_out_nxt;
  logic [N_REQ-1:0]    gnt_nxt, cv_nxt, req_eff, arb_gnt;
  logic [PTR_W-1:0]    arb_idx;
  logic                src_req_nxt, terr_nxt;
  logic [CNT_W-1:0]    dealt_nxt;

  // A hand whose strobe is showing this cycle is already served; keep it out
  // of arbitration so a slow req drop cannot cause a double draw.
  assign req_eff = req & ~card_valid;

  rr_arbiter #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_arb (
    .req     (req_eff),
    .ptr     (ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  assign busy          = (state != ST_IDLE);
  assign reshuffle_req = (state == ST_SHUFFLE);

  // Next-state and next-register values; flush overrides last.
  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    win_nxt      = win;
    timer_nxt    = timer;
    card_q_nxt   = card_q;
    card_out_nxt = card_out;
    gnt_nxt      = gnt;
    cv_nxt       = '0;
    src_req_nxt  = src_req;
    terr_nxt     = timeout_err;
    dealt_nxt    = cards_dealt;
    case (state)
      ST_IDLE: begin
        if (cards_dealt >= CNT_W'(RESHUFFLE_AT)) begin
          state_nxt = ST_SHUFFLE;
        end else if (|req_eff) begin
          gnt_nxt     = arb_gnt;
          src_req_nxt = 1'b1;
          timer_nxt   = '0;
          win_nxt     = arb_idx;
          ptr_nxt     = (int'(arb_idx) == N_REQ - 1) ? '0 : PTR_W'(arb_idx + 1'b1);
          state_nxt   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (src_ack) begin
          if (src_card == '0) begin
            timer_nxt = '0;  // invalid card: retry with a fresh timeout window
          end else begin
            card_q_nxt  = src_card;
            src_req_nxt = 1'b0;
            state_nxt   = ST_DELIVER;
          end
        end else if (timer == TMR_W'(TIMEOUT)) begin
          terr_nxt    = 1'b1;
          src_req_nxt = 1'b0;
          gnt_nxt     = '0;
          state_nxt   = ST_IDLE;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      ST_DELIVER: begin
        dealt_nxt = (cards_dealt == '1) ? cards_dealt : cards_dealt + 1'b1;
        if (req[win]) begin
          cv_nxt[win]  = 1'b1;
          card_out_nxt = card_q;
        end
        gnt_nxt   = '0;
        state_nxt = ST_IDLE;
      end
      ST_SHUFFLE: begin
        if (reshuffle_done) begin
          dealt_nxt = '0;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Round abort: drop the draw but keep fairness pointer and deck count.
    if (flush && state != ST_SHUFFLE) begin
      src_req_nxt = 1'b0;
      gnt_nxt     = '0;
      cv_nxt      = '0;
      terr_nxt    = 1'b0;
      ptr_nxt     = ptr;
      dealt_nxt   = cards_dealt;
      state_nxt   = ST_IDLE;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      win         <= '0;
      timer       <= '0;
      card_q      <= '0;
      card_out    <= '0;
      gnt         <= '0;
      card_valid  <= '0;
      src_req     <= 1'b0;
      timeout_err <= 1'b0;
      cards_dealt <= '0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      win         <= win_nxt;
      timer       <= timer_nxt;
      card_q      <= card_q_nxt;
      card_out    <= card_out_nxt;
      gnt         <= gnt_nxt;
      card_valid  <= cv_nxt;
      src_req     <= src_req_nxt;
      timeout_err <= terr_nxt;
      cards_dealt <= dealt_nxt;
    end
  end

endmodule

// File: tb/tb_card_draw_arbiter.sv
// Directed bench with a strobe scoreboard: stimulus pushes expected deliveries,
// a monitor pops and compares on every card_valid strobe.
module tb_card_draw_arbiter;

  logic       clk = 1'b0;
  logic       reset, flush, src_ack, reshuffle_done;
  logic [2:0] req, gnt, card_valid;
  logic [3:0] card_out, src_card;
  logic       src_req, busy, timeout_err, reshuffle_req;
  logic [5:0] cards_dealt;

  typedef struct packed {
    logic [2:0] cv;
    logic [3:0] card;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  card_draw_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .req            (req),
    .gnt            (gnt),
    .card_out       (card_out),
    .card_valid     (card_valid),
    .src_req        (src_req),
    .src_ack        (src_ack),
    .src_card       (src_card),
    .busy           (busy),
    .timeout_err    (timeout_err),
    .cards_dealt    (cards_dealt),
    .reshuffle_req  (reshuffle_req),
    .reshuffle_done (reshuffle_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Monitor: every strobe must match the oldest expected delivery.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && card_valid != 3'b000) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_strobe: got cv=%b card=%0d expected none", card_valid, card_out);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("strobe_cv", 32'(card_valid), 32'(e.cv));
          check("strobe_card", 32'(card_out), 32'(e.card));
        end
      end
    end
  end

  task automatic do_reset();
    req = '0; flush = 0; src_ack = 0; src_card = '0; reshuffle_done = 0;
    reset = 1;
    repeat (2) tick();
    reset = 0;
    tick();
  endtask

  task automatic wait_gnt(input int idx);
    int n = 0;
    tick();
    while (!(gnt[idx] && src_req) && n < 50) begin tick(); n++; end
    check("gnt_seen", 32'(gnt[idx] && src_req), 1);
  endtask

  task automatic wait_strobe(input int idx);
    int n = 0;
    while (!card_valid[idx] && n < 50) begin tick(); n++; end
    check("strobe_seen", 32'(card_valid[idx]), 1);
  endtask

  // One full draw for hand idx; ack arrives dly cycles after grant.
  task automatic draw(input int idx, input logic [3:0] card, input int dly);
    logic [2:0] oh;
    oh = 3'b001 << idx;
    req[idx] = 1'b1;
    wait_gnt(idx);
    check("gnt_onehot", 32'(gnt), 32'(oh));
    repeat (dly) tick();
    src_ack = 1; src_card = card;
    exp_q.push_back({oh, card});
    tick();
    src_ack = 0; src_card = '0;
    wait_strobe(idx);
    req[idx] = 1'b0;
  endtask

  initial begin
    int cnt;
    logic [2:0] order [4];
    order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100; order[3] = 3'b001;

    // Reset state
    do_reset();
    check("rst_gnt", 32'(gnt), 0);
    check("rst_cv", 32'(card_valid), 0);
    check("rst_ctl", 32'({src_req, busy, timeout_err, reshuffle_req}), 0);
    check("rst_cards", 32'(cards_dealt), 0);
    check("rst_card_out", 32'(card_out), 0);

    // Contention: all hands held, immediate acks, back-to-back grants
    req = 3'b111;
    wait_gnt(0);
    for (int k = 0; k < 4; k++) begin
      check("rr_gnt", 32'(gnt), 32'(order[k]));
      src_ack = 1; src_card = 4'(k + 2);
      exp_q.push_back({order[k], 4'(k + 2)});
      tick();
      src_ack = 0; src_card = '0;
      tick();
      check("rr_strobe_now", 32'(card_valid), 32'(order[k]));
      tick();  // next grant must appear one cycle after the strobe
    end
    req = '0;
    check("rr_cards", 32'(cards_dealt), 4);
    tick(); tick();

    // Single draw, ack two cycles after src_req
    do_reset();
    draw(1, 4'd7, 2);
    check("single_cards", 32'(cards_dealt), 1);

    // Timeout then flush
    do_reset();
    req = 3'b001;
    wait_gnt(0);
    cnt = 0;
    while (!timeout_err && cnt < 40) begin tick(); cnt++; end
    req = '0;
    check("to_err", 32'(timeout_err), 1);
    check("to_window", 32'(cnt >= 15 && cnt <= 16), 1);
    check("to_src_req", 32'(src_req), 0);
    check("to_gnt", 32'(gnt), 0);
    tick();
    check("to_err_sticky", 32'(timeout_err), 1);
    flush = 1; tick(); flush = 0;
    check("flush_clr", 32'(timeout_err), 0);
    check("to_cards", 32'(cards_dealt), 0);

    // Invalid card then valid card
    do_reset();
    req = 3'b100;
    wait_gnt(2);
    src_ack = 1; src_card = 4'd0;
    tick();
    check("inv_src_req", 32'(src_req), 1);
    src_card = 4'd9;
    exp_q.push_back({3'b100, 4'd9});
    tick();
    src_ack = 0; src_card = '0;
    wait_strobe(2);
    req = '0;
    check("inv_cards", 32'(cards_dealt), 1);

    // Withdraw in WAIT: card burned, counted, no strobe
    do_reset();
    req = 3'b010;
    wait_gnt(1);
    req = '0;
    tick();
    src_ack = 1; src_card = 4'd4;
    tick();
    src_ack = 0; src_card = '0;
    repeat (3) tick();
    check("burn_cards", 32'(cards_dealt), 1);
    check("burn_gnt", 32'(gnt), 0);

    // Async reset mid-draw
    do_reset();
    req = 3'b001;
    wait_gnt(0);
    #2 reset = 1;
    #1;
    check("arst_outs", 32'({gnt, card_valid, src_req, busy}), 0);
    req = '0;
    tick();
    reset = 0;
    tick();

    // Reshuffle after a full deck
    do_reset();
    for (int i = 0; i < 40; i++) draw(i % 3, 4'((i % 10) + 1), 0);
    check("deck_cards", 32'(cards_dealt), 40);
    req = 3'b010;
    tick();
    check("shuf_req", 32'(reshuffle_req), 1);
    check("shuf_busy", 32'(busy), 1);
    flush = 1; tick(); flush = 0;
    repeat (2) tick();
    check("shuf_hold_gnt", 32'(gnt), 0);
    check("shuf_flush_ign", 32'(reshuffle_req), 1);
    reshuffle_done = 1; tick(); reshuffle_done = 0;
    check("shuf_cards", 32'(cards_dealt), 0);
    check("shuf_done", 32'(reshuffle_req), 0);
    draw(1, 4'd5, 1);
    check("post_shuf_cards", 32'(cards_dealt), 1);

    repeat (3) tick();
    check("sb_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
